// File: rtl/control_unit_pkg.sv
// Shared RV32I decode constants, ALU operation encoding and the funct3-to-ALU mapping
// used by control_unit and alu_base.
package control_unit_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_DM   = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_NONE = 2'd3;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef enum logic [1:0] {
    A_RS1  = 2'd0,
    A_PC   = 2'd1,
    A_ZERO = 2'd2
  } a_src_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  // bit30 means SUB only for register-register ops; it always selects SRA on funct3 101.
  function automatic alu_op_e alu_op_from_funct3(input logic [2:0] funct3,
                                                 input logic       bit30,
                                                 input logic       is_op);
    alu_op_e op;
    case (funct3)
      3'b000:  op = (is_op && bit30) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = bit30 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/control_unit_alu_base.sv
// Combinational 32-bit RV32I ALU: add/sub wrap, shifts use b[4:0], compares return 0/1.
module alu_base
  import control_unit_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  output logic [31:0] result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    result = 32'd0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {31'd0, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = 32'($signed(a) >>> shamt);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = 32'd0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// RV32I decode-and-execute for the multi-cycle core: decode, operand select, ALU,
// branch compare, and a sticky illegal-opcode flag (the only registered state).
module control_unit
  import control_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [31:0] instruction,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic [4:0]  rf_rsel1,
  output logic [4:0]  rf_rsel2,
  output logic [4:0]  rf_wsel,
  output logic        rf_wen,
  output logic [1:0]  rf_wdata_sel,
  output logic        dm_wen,
  output logic [31:0] alu_out,
  output logic        branch_taken,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       bit30;
  logic       unused_instr_bits;

  assign opcode            = instruction[6:0];
  assign funct3            = instruction[14:12];
  assign bit30             = instruction[30];
  assign unused_instr_bits = ^{instruction[31], instruction[29:25]};

  assign rf_rsel1 = instruction[19:15];
  assign rf_rsel2 = instruction[24:20];
  assign rf_wsel  = instruction[11:7];

  a_src_e     a_src;
  logic       b_is_rs2;
  alu_op_e    alu_op;
  logic       wen_raw;
  logic [1:0] wdata_sel;
  logic       store_en;
  logic       is_branch;
  logic       is_jalr;
  logic       zero_out;
  logic       supported;

  always_comb begin
    a_src     = A_RS1;
    b_is_rs2  = 1'b0;
    alu_op    = ALU_ADD;
    wen_raw   = 1'b0;
    wdata_sel = WB_NONE;
    store_en  = 1'b0;
    is_branch = 1'b0;
    is_jalr   = 1'b0;
    zero_out  = 1'b0;
    supported = 1'b1;
    case (opcode)
      OPC_LUI:    begin a_src = A_ZERO; wen_raw = 1'b1; wdata_sel = WB_ALU; end
      OPC_AUIPC:  begin a_src = A_PC;   wen_raw = 1'b1; wdata_sel = WB_ALU; end
      OPC_JAL:    begin a_src = A_PC;   wen_raw = 1'b1; wdata_sel = WB_PC4; end
      OPC_JALR:   begin is_jalr = 1'b1; wen_raw = 1'b1; wdata_sel = WB_PC4; end
      OPC_BRANCH: begin a_src = A_PC;   is_branch = 1'b1; end
      OPC_LOAD:   begin wen_raw = 1'b1; wdata_sel = WB_DM; end
      OPC_STORE:  store_en = 1'b1;
      OPC_OP_IMM: begin
        alu_op    = alu_op_from_funct3(funct3, bit30, 1'b0);
        wen_raw   = 1'b1;
        wdata_sel = WB_ALU;
      end
      OPC_OP: begin
        b_is_rs2  = 1'b1;
        alu_op    = alu_op_from_funct3(funct3, bit30, 1'b1);
        wen_raw   = 1'b1;
        wdata_sel = WB_ALU;
      end
      OPC_FENCE, OPC_SYSTEM: zero_out = 1'b1;
      default: begin
        zero_out  = 1'b1;
        supported = 1'b0;
      end
    endcase
  end

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_result;

  always_comb begin
    op_a = rf_rdata1;
    case (a_src)
      A_PC:    op_a = pc;
      A_ZERO:  op_a = 32'd0;
      default: op_a = rf_rdata1;
    endcase
    op_b = b_is_rs2 ? rf_rdata2 : imm;
  end

  alu_base u_alu (
    .a      (op_a),
    .b      (op_b),
    .op     (alu_op),
    .result (alu_result)
  );

  logic br_eq;
  logic br_lt;
  logic br_ltu;
  logic br_cond;

  assign br_eq  = (rf_rdata1 == rf_rdata2);
  assign br_lt  = ($signed(rf_rdata1) < $signed(rf_rdata2));
  assign br_ltu = (rf_rdata1 < rf_rdata2);

  always_comb begin
    br_cond = 1'b0;
    case (funct3)
      BR_BEQ:  br_cond = br_eq;
      BR_BNE:  br_cond = !br_eq;
      BR_BLT:  br_cond = br_lt;
      BR_BGE:  br_cond = !br_lt;
      BR_BLTU: br_cond = br_ltu;
      BR_BGEU: br_cond = !br_ltu;
      default: br_cond = 1'b0;
    endcase
  end

  // JALR target clears bit 0 after the add; writes to x0 are suppressed here.
  always_comb begin
    alu_out = alu_result;
    if (zero_out) alu_out = 32'd0;
    else if (is_jalr) alu_out = {alu_result[31:1], 1'b0};
    rf_wen       = wen_raw && (rf_wsel != 5'd0);
    rf_wdata_sel = wdata_sel;
    dm_wen       = store_en;
    branch_taken = is_branch && br_cond;
  end

  logic illegal_q;
  logic illegal_d;

  always_comb begin
    illegal_d = illegal_q;
    if (valid && !supported) illegal_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: table of decode/ALU/branch vectors plus
// hand-written sequences for the sticky illegal flag and its reset.
module tb_control_unit;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic [4:0]  rf_rsel1;
  logic [4:0]  rf_rsel2;
  logic [4:0]  rf_wsel;
  logic        rf_wen;
  logic [1:0]  rf_wdata_sel;
  logic        dm_wen;
  logic [31:0] alu_out;
  logic        branch_taken;
  logic        illegal;

  int n_checks = 0;
  int n_fail   = 0;

  control_unit dut (
    .clk          (clk),
    .rst          (rst),
    .valid        (valid),
    .instruction  (instruction),
    .pc           (pc),
    .imm          (imm),
    .rf_rdata1    (rf_rdata1),
    .rf_rdata2    (rf_rdata2),
    .rf_rsel1     (rf_rsel1),
    .rf_rsel2     (rf_rsel2),
    .rf_wsel      (rf_wsel),
    .rf_wen       (rf_wen),
    .rf_wdata_sel (rf_wdata_sel),
    .dm_wen       (dm_wen),
    .alu_out      (alu_out),
    .branch_taken (branch_taken),
    .illegal      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        valid;
    logic [31:0] exp_alu;
    logic        exp_wen;
    logic [1:0]  exp_sel;
    logic        exp_dm;
    logic        exp_br;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [31:0] instr, input logic [31:0] vpc,
                         input logic [31:0] vimm, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic vv,
                         input logic [31:0] e_alu, input logic e_wen,
                         input logic [1:0] e_sel, input logic e_dm, input logic e_br);
    vec_t v;
    v = '{instr, vpc, vimm, rs1, rs2, vv, e_alu, e_wen, e_sel, e_dm, e_br};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] vpc,
                       input logic [31:0] vimm, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic vv);
    instruction = instr;
    pc          = vpc;
    imm         = vimm;
    rf_rdata1   = rs1;
    rf_rdata2   = rs2;
    valid       = vv;
  endtask

  initial begin
    //      instr         pc           imm          rs1          rs2          v  alu          wen sel dm br
    add_vec(32'h002081B3, 32'h0,       32'h0,       32'd7,       32'd5,       1, 32'd12,       1, 0, 0, 0); // ADD
    add_vec(32'h402081B3, 32'h0,       32'h0,       32'd7,       32'd5,       1, 32'd2,        1, 0, 0, 0); // SUB
    add_vec(32'h4020D193, 32'h0,       32'h402,     32'h80000000, 32'h0,      1, 32'hE0000000, 1, 0, 0, 0); // SRAI
    add_vec(32'h0020D193, 32'h0,       32'h002,     32'h80000000, 32'h0,      1, 32'h20000000, 1, 0, 0, 0); // SRLI
    add_vec(32'h0020C063, 32'h100,     32'h8,       32'hFFFFFFFF, 32'd1,      1, 32'h108,      0, 3, 0, 1); // BLT
    add_vec(32'h0020E063, 32'h100,     32'h8,       32'hFFFFFFFF, 32'd1,      1, 32'h108,      0, 3, 0, 0); // BLTU
    add_vec(32'h00208063, 32'h100,     32'h8,       32'h55,      32'h55,      1, 32'h108,      0, 3, 0, 1); // BEQ
    add_vec(32'h00209063, 32'h0,       32'h10,      32'h55,      32'h55,      1, 32'h10,       0, 3, 0, 0); // BNE equal
    add_vec(32'h0020D063, 32'h0,       32'h10,      32'd5,       32'd5,       1, 32'h10,       0, 3, 0, 1); // BGE equal
    add_vec(32'h0020F063, 32'h0,       32'h10,      32'd1,       32'hFFFFFFFF, 1, 32'h10,      0, 3, 0, 0); // BGEU
    add_vec(32'h0020A063, 32'h0,       32'h10,      32'd1,       32'd1,       1, 32'h10,       0, 3, 0, 0); // funct3 010
    add_vec(32'h000100E7, 32'h0,       32'd4,       32'h80000101, 32'h0,      1, 32'h80000104, 1, 2, 0, 0); // JALR
    add_vec(32'hFE20AE23, 32'h0,       32'hFFFFFFFC, 32'h1000,   32'h0,       1, 32'hFFC,      0, 3, 1, 0); // SW
    add_vec(32'h0000A003, 32'h0,       32'h10,      32'h2000,    32'h0,       1, 32'h2010,     0, 1, 0, 0); // LW x0
    add_vec(32'h0000A083, 32'h0,       32'h10,      32'h2000,    32'h0,       1, 32'h2010,     1, 1, 0, 0); // LW x1
    add_vec(32'h123452B7, 32'h500,     32'h12345000, 32'hDEAD,   32'h0,       1, 32'h12345000, 1, 0, 0, 0); // LUI
    add_vec(32'h00001297, 32'h400,     32'h1000,    32'hDEAD,    32'h0,       1, 32'h1400,     1, 0, 0, 0); // AUIPC
    add_vec(32'h008000EF, 32'h200,     32'h8,       32'hDEAD,    32'h0,       1, 32'h208,      1, 2, 0, 0); // JAL
    add_vec(32'h0020A1B3, 32'h0,       32'h0,       32'hFFFFFFFF, 32'd1,      1, 32'd1,        1, 0, 0, 0); // SLT
    add_vec(32'h0020B1B3, 32'h0,       32'h0,       32'hFFFFFFFF, 32'd1,      1, 32'd0,        1, 0, 0, 0); // SLTU
    add_vec(32'h0020C1B3, 32'h0,       32'h0,       32'h0000F0F0, 32'h0FF0,   1, 32'h0000FF00, 1, 0, 0, 0); // XOR
    add_vec(32'h0020E1B3, 32'h0,       32'h0,       32'h0000F0F0, 32'h0FF0,   1, 32'h0000FFF0, 1, 0, 0, 0); // OR
    add_vec(32'h0020F1B3, 32'h0,       32'h0,       32'h0000F0F0, 32'h0FF0,   1, 32'h000000F0, 1, 0, 0, 0); // AND
    add_vec(32'h002091B3, 32'h0,       32'h0,       32'd1,       32'h21,      1, 32'd2,        1, 0, 0, 0); // SLL uses b[4:0]
    add_vec(32'h40008093, 32'h0,       32'h400,     32'd1,       32'h0,       1, 32'h401,      1, 0, 0, 0); // ADDI bit30 set
    add_vec(32'h00208033, 32'h0,       32'h0,       32'd7,       32'd5,       1, 32'd12,       0, 0, 0, 0); // ADD rd=x0
    add_vec(32'hFFFFFFFF, 32'h0,       32'h0,       32'h12345678, 32'h12345678, 1, 32'hFFFFFFFE, 1, 0, 0, 0); // ADD wrap
    add_vec(32'h0000000F, 32'h40,      32'h4,       32'h11,      32'h22,      1, 32'd0,        0, 3, 0, 0); // FENCE
    add_vec(32'h00000073, 32'h40,      32'h4,       32'h11,      32'h22,      1, 32'd0,        0, 3, 0, 0); // SYSTEM
    add_vec(32'h0020807F, 32'h40,      32'h4,       32'h11,      32'h11,      0, 32'd0,        0, 3, 0, 0); // bad opcode, not valid

    // 0xFFFFFFFF decodes as opcode 1111111: unsupported, so fix its entry up.
    vecs[26].instr   = 32'hFFFFF1B3 & 32'h7FFFFFFF;
    vecs[26].imm     = 32'h0;
    vecs[26].exp_alu = 32'h2468ACF0;
    vecs[26].rs1     = 32'h92345678;
    vecs[26].rs2     = 32'h92345678;
    // instr 0x7FFFF1B3: OP, funct3 111 -> AND; use ADD form instead.
    vecs[26].instr   = 32'h3FFF81B3;
    vecs[26].exp_alu = 32'h2468ACF0;

    rst = 1'b1;
    drive(32'h00000013, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset illegal", {31'd0, illegal}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].instr, vecs[i].pc, vecs[i].imm, vecs[i].rs1, vecs[i].rs2, vecs[i].valid);
      #1;
      check($sformatf("v%0d alu_out", i), alu_out, vecs[i].exp_alu);
      check($sformatf("v%0d rf_wen", i), {31'd0, rf_wen}, {31'd0, vecs[i].exp_wen});
      check($sformatf("v%0d wdata_sel", i), {30'd0, rf_wdata_sel}, {30'd0, vecs[i].exp_sel});
      check($sformatf("v%0d dm_wen", i), {31'd0, dm_wen}, {31'd0, vecs[i].exp_dm});
      check($sformatf("v%0d branch", i), {31'd0, branch_taken}, {31'd0, vecs[i].exp_br});
      check($sformatf("v%0d rsel1", i), {27'd0, rf_rsel1}, {27'd0, vecs[i].instr[19:15]});
      check($sformatf("v%0d rsel2", i), {27'd0, rf_rsel2}, {27'd0, vecs[i].instr[24:20]});
      check($sformatf("v%0d wsel", i), {27'd0, rf_wsel}, {27'd0, vecs[i].instr[11:7]});
      check($sformatf("v%0d illegal", i), {31'd0, illegal}, 32'd0);
    end

    // Bad opcode with valid: flag rises only after the clock edge.
    @(negedge clk);
    drive(32'h0000007F, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    #1;
    check("illegal before edge", {31'd0, illegal}, 32'd0);
    check("bad opcode alu_out", alu_out, 32'd0);
    check("bad opcode wdata_sel", {30'd0, rf_wdata_sel}, 32'd3);
    @(negedge clk);
    check("illegal set", {31'd0, illegal}, 32'd1);
    drive(32'h002081B3, 32'h0, 32'h0, 32'd7, 32'd5, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("illegal sticky", {31'd0, illegal}, 32'd1);
    end

    // Reset clears it, and wins over a simultaneous bad opcode.
    drive(32'h0000007F, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("illegal rst priority", {31'd0, illegal}, 32'd0);
    rst = 1'b0;
    drive(32'h002081B3, 32'h0, 32'h0, 32'd7, 32'd5, 1'b1);
    @(negedge clk);
    check("illegal after rst", {31'd0, illegal}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
